// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bus bundle between the fetch stage, the program ROM and the decoder.
//   mem_rd      : ROM read strobe                    (fetch -> ROM)
//   mem_addr    : ROM address                        (fetch -> ROM)
//   mem_data    : ROM read data, one cycle after rd  (ROM -> fetch)
//   instr       : held instruction word              (fetch -> decoder)
//   instr_valid : instr is valid                     (fetch -> decoder)
//   instr_ready : decoder accepts instr              (decoder -> fetch)
//   jmp         : decoder jump flag                  (decoder -> fetch)
//   rst_f       : decoder soft reset, active-low     (decoder -> fetch)
//   jmp_addr    : jump target                        (decoder -> fetch)
// Modport master is the fetch stage; slave is the ROM/decoder side.
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
    parameter int CNTR_WIDTH  = 8,
    parameter int INSTR_WIDTH = 24
);
    logic                   mem_rd;
    logic [CNTR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_data;
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   jmp;
    logic                   rst_f;
    logic [CNTR_WIDTH-1:0]  jmp_addr;

    modport master (
        output mem_rd, mem_addr, instr, instr_valid,
        input  mem_data, instr_ready, jmp, rst_f, jmp_addr
    );

    modport slave (
        input  mem_rd, mem_addr, instr, instr_valid,
        output mem_data, instr_ready, jmp, rst_f, jmp_addr
    );
endinterface

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Program counter and fetch stage. Reads one word per fetch from a synchronous
// ROM (data valid one cycle after mem_rd), holds it for the decoder behind a
// valid/ready handshake, and redirects the PC on the handshake cycle from the
// decoder's soft-reset / jump flags.
// Ports:
//   clk         : clock, rising edge
//   rst_n       : hard reset, asynchronous, active-low
//   bus         : instruction_fetch_if.master (ROM + decoder signals)
//   pc          : next fetch address (same as bus.mem_addr)
//   issue_count : number of completed handshakes, wraps
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int                    CNTR_WIDTH   = 8,
    parameter int                    INSTR_WIDTH  = 24,
    parameter logic [CNTR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    instruction_fetch_if.master    bus,
    output logic [CNTR_WIDTH-1:0]  pc,
    output logic [COUNT_WIDTH-1:0] issue_count
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, ISSUE} state_t;

    state_t                 state_reg,  state_next;
    logic [CNTR_WIDTH-1:0]  pc_reg,     pc_next;
    logic [INSTR_WIDTH-1:0] instr_reg,  instr_next;
    logic [COUNT_WIDTH-1:0] count_reg,  count_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_VECTOR;
            instr_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            count_reg <= count_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE:  state_next = FETCH;
            FETCH: state_next = WAIT;
            WAIT: begin
                // ROM data for the FETCH address is on mem_data now. The PC
                // advances here so a plain handshake needs no further update.
                instr_next = bus.mem_data;
                pc_next    = pc_reg + CNTR_WIDTH'(1);
                state_next = ISSUE;
            end
            ISSUE: begin
                // Redirect flags matter only on the handshake cycle.
                if (bus.instr_ready) begin
                    count_next = count_reg + COUNT_WIDTH'(1);
                    if (!bus.rst_f)
                        pc_next = RESET_VECTOR;
                    else if (bus.jmp)
                        pc_next = bus.jmp_addr;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Strobes are pure decodes of the state register.
    assign bus.mem_rd      = (state_reg == FETCH);
    assign bus.instr_valid = (state_reg == ISSUE);
    assign bus.mem_addr    = pc_reg;
    assign bus.instr       = instr_reg;
    assign pc              = pc_reg;
    assign issue_count     = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Table-driven bench: each row gives the inputs applied before a rising edge
// and the outputs expected just after it. ROM[i] = i + 0x100. A hand-written
// sequence then covers asynchronous reset in the middle of WAIT.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instruction_fetch_if #(.CNTR_WIDTH(8), .INSTR_WIDTH(24)) bus ();

    logic [7:0]  pc;
    logic [15:0] issue_count;

    instruction_fetch #(
        .CNTR_WIDTH  (8),
        .INSTR_WIDTH (24),
        .RESET_VECTOR(8'h00),
        .COUNT_WIDTH (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .pc         (pc),
        .issue_count(issue_count)
    );

    // Synchronous ROM model: registered read, data one cycle after mem_rd.
    logic [23:0] rom [256];
    logic [23:0] rom_q = '0;
    always @(posedge clk) if (bus.mem_rd) rom_q <= rom[bus.mem_addr];
    assign bus.mem_data = rom_q;

    typedef struct {
        logic        ready;
        logic        jmp;
        logic        rst_f;
        logic [7:0]  jaddr;
        logic        e_rd;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [23:0] e_instr;
        logic [15:0] e_count;
    } vec_t;

    vec_t vecs[$];
    int total = 0;
    int bad   = 0;

    task automatic add(input logic ready, input logic jmp, input logic rst_f,
                       input logic [7:0] jaddr, input logic e_rd,
                       input logic [7:0] e_addr, input logic e_valid,
                       input logic [23:0] e_instr, input logic [15:0] e_count);
        vec_t v;
        v.ready = ready; v.jmp = jmp; v.rst_f = rst_f; v.jaddr = jaddr;
        v.e_rd = e_rd; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_instr = e_instr; v.e_count = e_count;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_rd, input logic [7:0] e_addr,
                                 input logic e_valid, input logic [23:0] e_instr,
                                 input logic [15:0] e_count);
        check({tag, ".mem_rd"},      32'(bus.mem_rd),      32'(e_rd));
        check({tag, ".mem_addr"},    32'(bus.mem_addr),    32'(e_addr));
        check({tag, ".pc"},          32'(pc),              32'(e_addr));
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(e_valid));
        check({tag, ".instr"},       32'(bus.instr),       32'(e_instr));
        check({tag, ".issue_count"}, 32'(issue_count),     32'(e_count));
        $display("%s: rd=%0b addr=%02h valid=%0b instr=%06h count=%0d",
                 tag, bus.mem_rd, bus.mem_addr, bus.instr_valid, bus.instr, issue_count);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 24'(i + 'h100);

        //   ready jmp rst_f jaddr | rd  addr valid instr      count
        // free run, ready held high
        add(1, 0, 1, 8'h00,  1, 8'h00, 0, 24'h000000, 0);  // E1 FETCH
        add(1, 0, 1, 8'h00,  0, 8'h00, 0, 24'h000000, 0);  // E2 WAIT
        add(1, 0, 1, 8'h00,  0, 8'h01, 1, 24'h000100, 0);  // E3 ISSUE
        add(1, 0, 1, 8'h00,  1, 8'h01, 0, 24'h000100, 1);
        add(1, 0, 1, 8'h00,  0, 8'h01, 0, 24'h000100, 1);
        add(1, 0, 1, 8'h00,  0, 8'h02, 1, 24'h000101, 1);
        add(1, 0, 1, 8'h00,  1, 8'h02, 0, 24'h000101, 2);
        add(1, 0, 1, 8'h00,  0, 8'h02, 0, 24'h000101, 2);
        add(1, 0, 1, 8'h00,  0, 8'h03, 1, 24'h000102, 2);
        add(1, 0, 1, 8'h00,  1, 8'h03, 0, 24'h000102, 3);
        // redirect flags outside ISSUE are ignored
        add(1, 1, 1, 8'h55,  0, 8'h03, 0, 24'h000102, 3);
        add(1, 1, 0, 8'h55,  0, 8'h04, 1, 24'h000103, 3);
        // backpressure: 5 stalled cycles, redirect flags ignored without ready
        for (int i = 0; i < 5; i++)
            add(0, 1, 0, 8'h66, 0, 8'h04, 1, 24'h000103, 3);
        // jump to 0x20 on handshake of word from address 3
        add(1, 1, 1, 8'h20,  1, 8'h20, 0, 24'h000103, 4);
        add(1, 1, 1, 8'h77,  0, 8'h20, 0, 24'h000103, 4);
        add(1, 0, 0, 8'h00,  0, 8'h21, 1, 24'h000120, 4);
        // soft reset beats jump
        add(1, 1, 0, 8'h40,  1, 8'h00, 0, 24'h000120, 5);
        add(1, 0, 1, 8'h00,  0, 8'h00, 0, 24'h000120, 5);
        add(1, 0, 1, 8'h00,  0, 8'h01, 1, 24'h000100, 5);
        // jump to 0xFF, then PC wraps to 0x00
        add(1, 1, 1, 8'hFF,  1, 8'hFF, 0, 24'h000100, 6);
        add(1, 0, 1, 8'h00,  0, 8'hFF, 0, 24'h000100, 6);
        add(1, 0, 1, 8'h00,  0, 8'h00, 1, 24'h0001FF, 6);
        add(1, 0, 1, 8'h00,  1, 8'h00, 0, 24'h0001FF, 7);
        add(1, 0, 1, 8'h00,  0, 8'h00, 0, 24'h0001FF, 7);
        add(0, 0, 1, 8'h00,  0, 8'h01, 1, 24'h000100, 7);
        add(1, 0, 1, 8'h00,  1, 8'h01, 0, 24'h000100, 8);
        add(1, 0, 1, 8'h00,  0, 8'h01, 0, 24'h000100, 8);  // WAIT, pc=1

        rst_n = 1'b0;
        bus.instr_ready = 1'b0;
        bus.jmp = 1'b0;
        bus.rst_f = 1'b1;
        bus.jmp_addr = '0;

        #12;
        check_outputs("reset", 0, 8'h00, 0, 24'h0, 0);

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            bus.instr_ready = vecs[i].ready;
            bus.jmp         = vecs[i].jmp;
            bus.rst_f       = vecs[i].rst_f;
            bus.jmp_addr    = vecs[i].jaddr;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_addr,
                          vecs[i].e_valid, vecs[i].e_instr, vecs[i].e_count);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of WAIT, between edges.
        bus.instr_ready = 1'b1;
        bus.jmp = 1'b0;
        bus.rst_f = 1'b1;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, 8'h00, 0, 24'h0, 0);
        @(posedge clk);
        #1;
        check_outputs("rst_hold", 0, 8'h00, 0, 24'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_E1", 1, 8'h00, 0, 24'h0, 0);
        @(posedge clk);
        #1;
        check_outputs("post_E2", 0, 8'h00, 0, 24'h0, 0);
        @(posedge clk);
        #1;
        check_outputs("post_E3", 0, 8'h01, 1, 24'h000100, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Program-counter and fetch stage feeding the instruction decoder. Holds the program counter, reads one instruction word per fetch from the synchronous program ROM, and presents it to the decoder through a valid/ready handshake. It takes back the decoder's `jmp` and active-low `rst_f` flags, plus a jump target, to redirect the next fetch.

## Interface
- `CNTR_WIDTH`, default 8: program counter and ROM address width.
- `INSTR_WIDTH`, default 24: instruction word width, equal to the decoder's combined data width.
- `RESET_VECTOR`, default 0: PC value after hard reset and after a soft reset.
- `COUNT_WIDTH`, default 16: width of the issued-instruction counter.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: hard reset, asynchronous, active-low.
- `mem_rd`  out  1: ROM read strobe.
- `mem_addr`  out  CNTR_WIDTH: ROM address; equals `pc`.
- `mem_data`  in  INSTR_WIDTH: ROM read data, valid exactly one cycle after `mem_rd`.
- `instr`  out  INSTR_WIDTH: held instruction word to the decoder `data_in`.
- `instr_valid`  out  1: `instr` is valid.
- `instr_ready`  in  1: downstream accepts `instr` this cycle.
- `jmp`  in  1: decoder jump flag.
- `rst_f`  in  1: decoder soft-reset flag, active-low.
- `jmp_addr`  in  CNTR_WIDTH: jump target.
- `pc`  out  CNTR_WIDTH: next fetch address.
- `issue_count`  out  COUNT_WIDTH: number of completed handshakes.

## Operation
- FSM states are IDLE, FETCH, WAIT and ISSUE; the state register is the only source of `mem_rd` and `instr_valid`.
- IDLE: `mem_rd`=0. Next state is FETCH unconditionally. This state is entered only from hard reset.
- FETCH: `mem_rd`=1 and `mem_addr`=`pc`. Next state is WAIT.
- WAIT: `mem_rd`=0.
  - Capture `mem_data` into `instr`.
  - Update `pc` ← `pc`+1, modulo 2^CNTR_WIDTH, so `{CNTR_WIDTH{1'b1}}` wraps to 0.
  - Next state is ISSUE.
- ISSUE: `instr_valid`=1, and `instr` is held stable while `instr_ready`=0.
- On `instr_ready`=1 in ISSUE, a handshake completes:
  - `issue_count` increments, wrapping at 2^COUNT_WIDTH.
  - If `rst_f`=0, then `pc` ← `RESET_VECTOR`.
  - Else if `jmp`=1, then `pc` ← `jmp_addr`.
  - Otherwise `pc` is unchanged, having already been incremented.
  - Next state is FETCH.
- Redirect priority is soft reset over jump over sequential. A soft reset does not clear `issue_count` or `instr`.
- `jmp`, `rst_f` and `jmp_addr` are sampled only on the handshake cycle and ignored in every other cycle and state.
- A jump to the current instruction's own address is legal and re-fetches it.
- `instr_valid` deasserts in the cycle after the handshake; `instr` keeps its last value until the next WAIT.

## Timing
- Reset values while `rst_n`=0, applied asynchronously:
  - state = IDLE
  - `pc` = `RESET_VECTOR`
  - `mem_rd` = 0
  - `mem_addr` = `RESET_VECTOR`
  - `instr` = 0
  - `instr_valid` = 0
  - `issue_count` = 0
- After `rst_n` releases, count rising edges from E1:
  - E1: IDLE→FETCH, so `mem_rd`=1 after E1.
  - E2: FETCH→WAIT.
  - E3: capture; `instr_valid`=1 after E3.
- Steady state with `instr_ready` held at 1: one instruction every 3 cycles, i.e. FETCH, WAIT, ISSUE.
- Redirect latency: the redirected address appears on `mem_addr` one cycle after the handshake edge, since FETCH follows immediately.
- `rst_n` asserted in any state, mid-WAIT or mid-ISSUE included:
  - the in-flight ROM data is discarded;
  - outputs return to reset values immediately, with no handshake completed.
- `instr_ready` held low in ISSUE stalls indefinitely with all outputs stable. `mem_rd` stays 0 during the stall.
- `instr_ready` asserted outside ISSUE has no effect.

## Test plan
- Reset then free-run: ROM[i]=i+0x100, `instr_ready`=1.
  - `mem_rd` high on cycles 1, 4, 7.
  - `instr`=0x000100, 0x000101, 0x000102 with `instr_valid` pulses one cycle wide.
  - `issue_count`=3 after the third handshake.
- Backpressure: hold `instr_ready`=0 for 5 cycles at ISSUE.
  - `instr` and `instr_valid`=1 are stable.
  - `mem_rd`=0 throughout.
  - `issue_count` is unchanged until `instr_ready` rises.
- Jump: at ISSUE of the word from address 3, `jmp`=1, `jmp_addr`=0x20, `rst_f`=1.
  - Next `mem_addr` is 0x20.
  - `jmp` pulses outside ISSUE do not change `pc`.
- Soft reset priority: at the handshake, `rst_f`=0 and `jmp`=1 with `jmp_addr`=0x40.
  - Next fetch is from `RESET_VECTOR`=0.
  - `issue_count` keeps counting.
- Wrap: with CNTR_WIDTH=8, jump to 0xFF with `instr_ready`=1.
  - After 0xFF is fetched, the next fetch is from 0x00.
- Async reset mid-WAIT: drop `rst_n` between edges.
  - All outputs are at reset values before the next edge.
  - After release, the first fetch is from `RESET_VECTOR` on E1+.
